// File: rtl/prog_lut.sv
// rtl/prog_lut.sv - run-time writable flop-based lookup table with block-load sequencer
module prog_lut #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 32,
  localparam int KEY_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic [KEY_W-1:0] rd_key,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             wr_en,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_err,
  input  logic             ld_start,
  input  logic [KEY_W-1:0] ld_base,
  input  logic [KEY_W:0]   ld_count,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  output logic             ld_busy,
  output logic             ld_done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [KEY_W-1:0] ptr_q, ptr_d;
  logic [KEY_W:0]   rem_q, rem_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             wr_err_q, wr_err_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             we;
  logic [KEY_W-1:0] w_key;
  logic [WIDTH-1:0] w_data;
  logic             count_ok;

  assign count_ok = (ld_count != '0) && (ld_count <= (KEY_W+1)'(DEPTH));

  // Direct writes only land in IDLE and load words only in LOAD, so one write port suffices.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    we      = 1'b0;
    w_key   = wr_key;
    w_data  = wr_data;
    case (state_q)
      S_IDLE: begin
        we = wr_en;
        if (ld_start && count_ok) begin
          state_d = S_LOAD;
          ptr_d   = ld_base;
          rem_d   = ld_count;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          we     = 1'b1;
          w_key  = ptr_q;
          w_data = ld_data;
          ptr_d  = ptr_q + KEY_W'(1);
          rem_d  = rem_q - (KEY_W+1)'(1);
          if (rem_q == (KEY_W+1)'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Write-first: a read colliding with the committing write returns the new value.
  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) rd_data_d = (we && (w_key == rd_key)) ? w_data : mem_q[rd_key];
    wr_err_d   = wr_en && (state_q != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_err_q   <= wr_err_d;
      if (we) mem_q[w_key] <= w_data;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign wr_err   = wr_err_q;
  assign ld_ready = (state_q == S_LOAD);
  assign ld_busy  = (state_q == S_LOAD);
  assign ld_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_prog_lut.sv
// tb/tb_prog_lut.sv - directed self-checking bench for prog_lut
module tb_prog_lut;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rd_en;
  logic [4:0] rd_key;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_en;
  logic [4:0] wr_key;
  logic [7:0] wr_data;
  logic       wr_err;
  logic       ld_start;
  logic [4:0] ld_base;
  logic [5:0] ld_count;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       ld_busy;
  logic       ld_done;

  int checks   = 0;
  int failures = 0;

  prog_lut #(.WIDTH(8), .DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_key(rd_key), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_key(wr_key), .wr_data(wr_data), .wr_err(wr_err),
    .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_busy(ld_busy), .ld_done(ld_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd1(input logic [4:0] key, input logic [7:0] exp, input string tag);
    rd_en = 1'b1; rd_key = key;
    tick();
    rd_en = 1'b0;
    chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; rd_key = '0; wr_en = 1'b0; wr_key = '0; wr_data = '0;
    ld_start = 1'b0; ld_base = '0; ld_count = '0; ld_valid = 1'b0; ld_data = '0;
    tick(); tick();
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst_outs", {27'd0, rd_valid, wr_err, ld_ready, ld_busy, ld_done}, 32'd0);
    rst_n = 1'b1;
    tick();

    // back-to-back reads after reset
    rd_en = 1'b1; rd_key = 5'd0;  tick();
    chk("rst_rd0", {23'd0, rd_valid, rd_data}, 32'h100);
    rd_key = 5'd5;  tick();
    chk("rst_rd5", {23'd0, rd_valid, rd_data}, 32'h100);
    rd_key = 5'd31; tick();
    chk("rst_rd31", {23'd0, rd_valid, rd_data}, 32'h100);
    rd_en = 1'b0; tick();
    chk("rd_valid_drop", {31'd0, rd_valid}, 32'd0);
    chk("rd_data_hold", {24'd0, rd_data}, 32'd0);

    // direct write then read, and same-cycle bypass
    wr_en = 1'b1; wr_key = 5'd3; wr_data = 8'h23; tick();
    wr_en = 1'b0;
    chk("wr_err_idle", {31'd0, wr_err}, 32'd0);
    rd1(5'd3, 8'h23, "wr_rd3");
    wr_en = 1'b1; wr_key = 5'd7; wr_data = 8'h8E;
    rd1(5'd7, 8'h8E, "bypass7");
    wr_en = 1'b0;
    rd1(5'd7, 8'h8E, "commit7");

    // wrapping load with a stall and a load-word bypass
    ld_start = 1'b1; ld_base = 5'd30; ld_count = 6'd4; tick();
    ld_start = 1'b0;
    chk("ld_start_busy", {30'd0, ld_busy, ld_ready}, 32'd3);
    ld_valid = 1'b1; ld_data = 8'hA1; tick();
    ld_valid = 1'b0; tick();
    chk("ld_stall_busy", {30'd0, ld_busy, ld_done}, 32'd2);
    ld_valid = 1'b1; ld_data = 8'hA2;
    rd1(5'd31, 8'hA2, "ld_bypass31");
    ld_data = 8'hA3; tick();
    chk("ld_pre_done", {31'd0, ld_done}, 32'd0);
    ld_data = 8'hA4; tick();
    ld_valid = 1'b0;
    chk("ld_done_pulse", {29'd0, ld_done, ld_busy, ld_ready}, 32'd4);
    ld_start = 1'b1; ld_count = 6'd2; tick();
    ld_start = 1'b0;
    chk("ld_done_once", {29'd0, ld_done, ld_busy, ld_ready}, 32'd0);
    tick();
    chk("start_in_done_ignored", {30'd0, ld_busy, ld_done}, 32'd0);
    rd1(5'd30, 8'hA1, "wrap30");
    rd1(5'd31, 8'hA2, "wrap31");
    rd1(5'd0,  8'hA3, "wrap0");
    rd1(5'd1,  8'hA4, "wrap1");
    rd1(5'd2,  8'h00, "wrap2_untouched");

    // IDLE write alongside ld_start, then rejected write during LOAD
    ld_start = 1'b1; ld_base = 5'd20; ld_count = 6'd2;
    wr_en = 1'b1; wr_key = 5'd12; wr_data = 8'h55; tick();
    ld_start = 1'b0;
    chk("start_with_wr_busy", {31'd0, ld_busy}, 32'd1);
    chk("start_with_wr_err", {31'd0, wr_err}, 32'd0);
    wr_key = 5'd10; wr_data = 8'hFF; tick();
    wr_en = 1'b0;
    chk("wr_err_load", {31'd0, wr_err}, 32'd1);
    ld_valid = 1'b1; ld_data = 8'h11; tick();
    chk("wr_err_one_pulse", {31'd0, wr_err}, 32'd0);
    ld_data = 8'h22; tick();
    ld_valid = 1'b0;
    chk("ld2_done", {31'd0, ld_done}, 32'd1);
    tick();
    rd1(5'd10, 8'h00, "rejected10");
    rd1(5'd12, 8'h55, "idle_wr12");
    rd1(5'd20, 8'h11, "ld20");
    rd1(5'd21, 8'h22, "ld21");

    // invalid counts are ignored
    ld_start = 1'b1; ld_count = 6'd0; tick();
    chk("cnt0_busy", {30'd0, ld_busy, ld_done}, 32'd0);
    ld_count = 6'd33; tick();
    ld_start = 1'b0;
    chk("cnt33_busy", {30'd0, ld_busy, ld_done}, 32'd0);
    tick();
    chk("cnt_bad_no_done", {30'd0, ld_busy, ld_done}, 32'd0);

    // full-table load from base 17
    ld_start = 1'b1; ld_base = 5'd17; ld_count = 6'd32; tick();
    ld_start = 1'b0;
    begin
      int busy_accepts = 0;
      ld_valid = 1'b1;
      for (int i = 0; i < 32; i++) begin
        if (ld_busy && ld_ready) busy_accepts++;
        ld_data = 8'(i + 1);
        tick();
      end
      ld_valid = 1'b0;
      chk("full_accepts", busy_accepts, 32'd32);
      chk("full_done", {30'd0, ld_busy, ld_done}, 32'd1);
    end
    tick();
    for (int k = 0; k < 32; k++) rd1(5'(k), 8'(((k + 32 - 17) % 32) + 1), $sformatf("full%0d", k));

    // reset in the middle of a load
    ld_start = 1'b1; ld_base = 5'd4; ld_count = 6'd5; tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 8'hC1; tick();
    ld_data = 8'hC2; tick();
    ld_valid = 1'b0;
    chk("mid_busy", {31'd0, ld_busy}, 32'd1);
    rst_n = 1'b0; #1;
    chk("mid_rst_async", {29'd0, ld_busy, ld_done, ld_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_no_done", {30'd0, ld_busy, ld_done}, 32'd0);
    for (int k = 0; k < 32; k++) rd1(5'(k), 8'h00, $sformatf("clr%0d", k));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
